// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost
// thresholds, registered error pulses and selectable registered/FWFT read.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_T     = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_T     = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr_reg, rd_ptr_reg;
  logic                  overflow_reg, underflow_reg;
  logic                  rd_ok, wr_ok;
  logic [AW-1:0]         wr_idx, rd_idx;

  assign wr_idx = wr_ptr_reg[AW-1:0];
  assign rd_idx = rd_ptr_reg[AW-1:0];

  // Status comes only from registered pointers, so it never glitches on inputs.
  assign count        = wr_ptr_reg - rd_ptr_reg;
  assign empty        = (wr_ptr_reg == rd_ptr_reg);
  assign full         = ((wr_ptr_reg ^ rd_ptr_reg) == FULL_XOR);
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  // A write into a full FIFO is allowed when the same edge frees a slot.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      overflow_reg  <= wr_en && !wr_ok;
      underflow_reg <= rd_en && empty;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  // Storage needs no reset: stale words are never observable.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = empty ? '0 : mem[rd_idx];
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data_reg <= '0;
        else if (rd_ok) rd_data_reg <= mem[rd_idx];
      end
      assign rd_data = rd_data_reg;
    end
  endgenerate

endmodule
